// File: rtl/hc_csr_pkg.sv
// hc_csr_pkg: CCI-P MMIO types, CSR byte offsets and control FSM
// state shared by the HardCloud CSR bank and its control sub-block.
package hc_csr_pkg;

  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mmioAddr;
  typedef logic [1:0]  t_ccip_mmioLen;
  typedef logic [8:0]  t_ccip_tid;
  typedef logic [63:0] t_ccip_mmioData;

  typedef struct packed {
    t_ccip_mmioAddr address;
    t_ccip_mmioLen  length;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    t_ccip_mmioData      data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  localparam t_ccip_mmioLen HC_LEN_4B = 2'd0;
  localparam t_ccip_mmioLen HC_LEN_8B = 2'd1;

  localparam int HC_DEVICE_HEADER   = 'h000;
  localparam int HC_AFU_ID_LOW      = 'h008;
  localparam int HC_AFU_ID_HIGH     = 'h010;
  localparam int HC_STATUS          = 'h100;
  localparam int HC_CYCLES          = 'h108;
  localparam int HC_DSM_BASE        = 'h110;
  localparam int HC_CONTROL         = 'h118;
  localparam int HC_BUFFER_BASE     = 'h120;
  localparam int HC_BUFFER_STRIDE   = 'h10;
  localparam int HC_BUFFER_SIZE_OFS = 'h08;

  localparam logic [63:0] HC_DFH =
    64'h1000_0100_0000_0000;

  localparam int HC_CTL_START = 0;
  localparam int HC_CTL_CLEAR = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } t_hc_ctl_state;

  // byte offset -> 64-bit register slot
  // (MMIO dword index with bit 0 dropped)
  function automatic logic [14:0] hc_qw(
    input int byte_off
  );
    return 15'(byte_off >> 3);
  endfunction

  // 8B writes replace the word, 4B writes
  // replace only the addressed half
  function automatic logic [63:0] hc_merge(
    input logic [63:0] old,
    input logic [63:0] wdat,
    input logic        len8,
    input logic        hi
  );
    if (len8) return wdat;
    if (hi) return {wdat[31:0], old[31:0]};
    return {old[63:32], wdat[31:0]};
  endfunction

endpackage

// File: rtl/hc_csr_ctl.sv
// hc_csr_ctl: start/busy/done job handshake and saturating run counter.
// Ports: clk, reset_n, start_wr, clear_wr, afu_done -> start, busy, done, cycles.
module hc_csr_ctl
  import hc_csr_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_wr,
  input  logic             clear_wr,
  input  logic             afu_done,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles
);

  t_hc_ctl_state    state_q, state_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    done_d  = done_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        // a start beats clear_done and afu_done
        if (start_wr) begin
          state_d = RUN;
          start_d = 1'b1;
          done_d  = 1'b0;
          cyc_d   = '0;
        end else if (clear_wr) begin
          done_d = 1'b0;
        end
      end
      RUN: begin
        if (clear_wr) done_d = 1'b0;
        if (afu_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (~&cyc_q) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start  = start_q;
    busy   = (state_q == RUN);
    done   = done_q;
    cycles = cyc_q;
  end

endmodule

// File: rtl/hc_csr_bank.sv
// hc_csr_bank: CCI-P MMIO CSR bank (DFH, AFU ID, DSM, buffer descriptors, control).
// Ports: clk, reset_n, rx/tx MMIO channels, afu_done, start, busy, mem_dsm, buf_addr, buf_lines.
module hc_csr_bank
  import hc_csr_pkg::*;
#(
  parameter int           NUM_BUFFERS = 2,
  parameter logic [127:0] AFU_ID      = '0,
  parameter int           CNT_W       = 48
) (
  input  logic           clk,
  input  logic           reset_n,
  input  t_if_ccip_c0_Rx rx_mmio_channel,
  output t_if_ccip_c2_Tx tx_mmio_channel,
  input  logic           afu_done,
  output logic           start,
  output logic           busy,
  output t_ccip_clAddr   mem_dsm,
  output t_ccip_clAddr [NUM_BUFFERS-1:0] buf_addr,
  output logic [NUM_BUFFERS-1:0][31:0]   buf_lines
);

  logic [14:0] qa;
  logic        hi;
  logic        len8;
  logic        wr_ok;
  logic        ctl_wr;
  logic [63:0] wdat;

  logic             start_wr;
  logic             clear_wr;
  logic             done;
  logic [CNT_W-1:0] cycles;

  logic [63:0] dsm_q;
  logic [NUM_BUFFERS-1:0][63:0] addr_q;
  logic [NUM_BUFFERS-1:0][63:0] size_q;

  logic [63:0] rd_qw;
  logic [63:0] rd_data;

  assign qa   = rx_mmio_channel.hdr.address[15:1];
  assign hi   = rx_mmio_channel.hdr.address[0];
  assign wdat = rx_mmio_channel.data;
  assign len8 =
    (rx_mmio_channel.hdr.length == HC_LEN_8B);

  // 8B writes to an odd dword index are dropped
  assign wr_ok = rx_mmio_channel.mmioWrValid &
    ((rx_mmio_channel.hdr.length == HC_LEN_4B) |
     (len8 & ~hi));

  assign ctl_wr = wr_ok & ~hi &
    (qa == hc_qw(HC_CONTROL));
  assign start_wr = ctl_wr & wdat[HC_CTL_START];
  assign clear_wr = ctl_wr & wdat[HC_CTL_CLEAR];

  hc_csr_ctl #(
    .CNT_W (CNT_W)
  ) u_ctl (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_wr (start_wr),
    .clear_wr (clear_wr),
    .afu_done (afu_done),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cycles   (cycles)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dsm_q  <= '0;
      addr_q <= '0;
      size_q <= '0;
    end else if (wr_ok) begin
      if (qa == hc_qw(HC_DSM_BASE))
        dsm_q <= hc_merge(dsm_q, wdat, len8, hi);
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (qa == hc_qw(HC_BUFFER_BASE +
                        HC_BUFFER_STRIDE * i))
          addr_q[i] <= hc_merge(addr_q[i], wdat,
                                len8, hi);
        if (qa == hc_qw(HC_BUFFER_BASE +
                        HC_BUFFER_STRIDE * i +
                        HC_BUFFER_SIZE_OFS))
          size_q[i] <= hc_merge(size_q[i], wdat,
                                len8, hi);
      end
    end
  end

  always_comb begin
    rd_qw = 64'h0;
    if (qa == hc_qw(HC_DEVICE_HEADER))
      rd_qw = HC_DFH;
    if (qa == hc_qw(HC_AFU_ID_LOW))
      rd_qw = AFU_ID[63:0];
    if (qa == hc_qw(HC_AFU_ID_HIGH))
      rd_qw = AFU_ID[127:64];
    if (qa == hc_qw(HC_STATUS))
      rd_qw = {62'h0, done, busy};
    if (qa == hc_qw(HC_CYCLES))
      rd_qw = 64'(cycles);
    if (qa == hc_qw(HC_DSM_BASE))
      rd_qw = dsm_q;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (qa == hc_qw(HC_BUFFER_BASE +
                      HC_BUFFER_STRIDE * i))
        rd_qw = addr_q[i];
      if (qa == hc_qw(HC_BUFFER_BASE +
                      HC_BUFFER_STRIDE * i +
                      HC_BUFFER_SIZE_OFS))
        rd_qw = size_q[i];
    end
  end

  // odd index returns the upper half in data[31:0]
  assign rd_data = hi ? {32'h0, rd_qw[63:32]} : rd_qw;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_mmio_channel <= '0;
    end else begin
      tx_mmio_channel.mmioRdValid <=
        rx_mmio_channel.mmioRdValid;
      tx_mmio_channel.hdr.tid <=
        rx_mmio_channel.hdr.tid;
      tx_mmio_channel.data <= rd_data;
    end
  end

  assign mem_dsm = dsm_q[47:6];

  always_comb begin
    buf_addr  = '0;
    buf_lines = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      buf_addr[i]  = addr_q[i][41:0];
      buf_lines[i] = size_q[i][31:0];
    end
  end

endmodule
